// File: rtl/i2c_reg_sequencer_pkg.sv
// rtl/i2c_reg_sequencer_pkg.sv - command codes and sequencer state types for i2c_reg_sequencer
//
// Contents:
//   k_*_CMD      3-bit command codes consumed by the bit-level I2C master
//   seq_state_e  sequencer states (k_SEQ_*)
//   seq_phase_e  per-command phase: ISSUE, SKIP (ignored cycle after accept), WAIT
//   addr_byte    builds the {dev, r/w} address byte
package i2c_reg_sequencer_pkg;

  localparam logic [2:0] k_START_CMD   = 3'd1;
  localparam logic [2:0] k_WRITE_CMD   = 3'd2;
  localparam logic [2:0] k_READ_CMD    = 3'd3;
  localparam logic [2:0] k_STOP_CMD    = 3'd4;
  localparam logic [2:0] k_RESTART_CMD = 3'd5;

  typedef enum logic [3:0] {
    k_SEQ_IDLE    = 4'd0,
    k_SEQ_START   = 4'd1,
    k_SEQ_DEV_W   = 4'd2,
    k_SEQ_REG     = 4'd3,
    k_SEQ_WDATA   = 4'd4,
    k_SEQ_RESTART = 4'd5,
    k_SEQ_DEV_R   = 4'd6,
    k_SEQ_RDATA   = 4'd7,
    k_SEQ_STOP    = 4'd8,
    k_SEQ_DONE    = 4'd9
  } seq_state_e;

  // SKIP is the first WAIT cycle: the master has just taken the command and
  // its ready_out is not yet meaningful.
  typedef enum logic [1:0] {
    k_PH_ISSUE = 2'd0,
    k_PH_SKIP  = 2'd1,
    k_PH_WAIT  = 2'd2
  } seq_phase_e;

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
    return {dev, rd};
  endfunction

endpackage

// File: rtl/i2c_cmd_watchdog.sv
// rtl/i2c_cmd_watchdog.sv - per-command watchdog counter for i2c_reg_sequencer
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   clr         clear the counter (command accepted by the master)
//   en          count this cycle (sequencer is waiting on the master)
//   expired     counter equals TIMEOUT_CYCLES while enabled
module i2c_cmd_watchdog #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Qualified by en so a stale count never fires outside a WAIT cycle.
  assign expired = en && (cnt_q == TIMEOUT_CYCLES);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - register read/write transaction sequencer in front of an I2C master
//
// Optional feature macro: I2C_SEQ_RETRY_EN (retry whole transaction on address NACK, up to 3 times).
//
// Ports:
//   clk, reset                         clock, asynchronous active-high reset
//   req_valid/req_ready                host request handshake (ready only in IDLE)
//   req_rw, req_dev_addr,
//   req_reg_addr, req_wdata            request fields, latched on accept
//   resp_valid                         one-cycle completion pulse
//   resp_rdata, resp_err, resp_timeout held result until the next accept
//   cmd, write, data_in, nack          command strobe and payload to the master
//   ready_out, rx_data, rx_ack         master idle flag and last READ byte / WRITE ack
module i2c_reg_sequencer
  import i2c_reg_sequencer_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       resp_timeout,
  output logic [2:0] cmd,
  output logic       write,
  output logic [7:0] data_in,
  output logic       nack,
  input  logic       ready_out,
  input  logic [7:0] rx_data,
  input  logic       rx_ack
);

  seq_state_e state_q, state_d;
  seq_phase_e phase_q, phase_d;
  logic       rw_q, rw_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic       tmo_q, tmo_d;
`ifdef I2C_SEQ_RETRY_EN
  logic [1:0] retry_cnt_q, retry_cnt_d;
  logic       retry_q, retry_d;
`endif

  logic busy;
  logic accept;
  logic wd_en;
  logic wd_expired;
  logic dev_nack;

  assign busy      = (state_q != k_SEQ_IDLE) && (state_q != k_SEQ_DONE);
  // Gated by reset so the host never sees ready while the block is held in reset.
  assign req_ready = (state_q == k_SEQ_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign write     = busy && (phase_q == k_PH_ISSUE);
  assign wd_en     = busy && (phase_q == k_PH_WAIT);

  assign resp_valid   = (state_q == k_SEQ_DONE);
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;
  assign resp_timeout = tmo_q;

  i2c_cmd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (write && ready_out),
    .en     (wd_en),
    .expired(wd_expired)
  );

  // Command payload follows the state; write alone qualifies it.
  always_comb begin
    cmd     = k_START_CMD;
    data_in = '0;
    nack    = 1'b0;
    case (state_q)
      k_SEQ_START:   cmd = k_START_CMD;
      k_SEQ_DEV_W: begin
        cmd     = k_WRITE_CMD;
        data_in = addr_byte(dev_q, 1'b0);
      end
      k_SEQ_REG: begin
        cmd     = k_WRITE_CMD;
        data_in = reg_q;
      end
      k_SEQ_WDATA: begin
        cmd     = k_WRITE_CMD;
        data_in = wdata_q;
      end
      k_SEQ_RESTART: cmd = k_RESTART_CMD;
      k_SEQ_DEV_R: begin
        cmd     = k_WRITE_CMD;
        data_in = addr_byte(dev_q, 1'b1);
      end
      k_SEQ_RDATA: begin
        cmd  = k_READ_CMD;
        nack = 1'b1;
      end
      k_SEQ_STOP:    cmd = k_STOP_CMD;
      default:       ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    rw_d     = rw_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    dev_nack = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
    retry_cnt_d = retry_cnt_q;
    retry_d     = retry_q;
`endif

    case (state_q)
      k_SEQ_IDLE: begin
        phase_d = k_PH_ISSUE;
        if (accept) begin
          rw_d    = req_rw;
          dev_d   = req_dev_addr;
          reg_d   = req_reg_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = k_SEQ_START;
`ifdef I2C_SEQ_RETRY_EN
          retry_cnt_d = '0;
          retry_d     = 1'b0;
`endif
        end
      end

      k_SEQ_DONE: begin
        state_d = k_SEQ_IDLE;
        phase_d = k_PH_ISSUE;
      end

      default: begin
        case (phase_q)
          // write is high throughout ISSUE, so ready_out alone means accepted;
          // the watchdog does not run here however long the master stalls.
          k_PH_ISSUE: if (ready_out) phase_d = k_PH_SKIP;
          k_PH_SKIP:  phase_d = k_PH_WAIT;
          default: begin
            // Completion beats a simultaneous expiry: the master did finish.
            if (ready_out) begin
              phase_d = k_PH_ISSUE;
              case (state_q)
                k_SEQ_START: state_d = k_SEQ_DEV_W;
                k_SEQ_DEV_W: begin
                  if (rx_ack) state_d = k_SEQ_REG;
                  else        dev_nack = 1'b1;
                end
                k_SEQ_REG: begin
                  if (!rx_ack) begin
                    err_d   = 1'b1;
                    state_d = k_SEQ_STOP;
                  end else begin
                    state_d = rw_q ? k_SEQ_RESTART : k_SEQ_WDATA;
                  end
                end
                k_SEQ_WDATA: begin
                  if (!rx_ack) err_d = 1'b1;
                  state_d = k_SEQ_STOP;
                end
                k_SEQ_RESTART: state_d = k_SEQ_DEV_R;
                k_SEQ_DEV_R: begin
                  if (rx_ack) state_d = k_SEQ_RDATA;
                  else        dev_nack = 1'b1;
                end
                k_SEQ_RDATA: begin
                  rdata_d = rx_data;
                  state_d = k_SEQ_STOP;
                end
                k_SEQ_STOP: begin
`ifdef I2C_SEQ_RETRY_EN
                  if (retry_q) begin
                    retry_d = 1'b0;
                    state_d = k_SEQ_START;
                  end else begin
                    state_d = k_SEQ_DONE;
                  end
`else
                  state_d = k_SEQ_DONE;
`endif
                end
                default: ;
              endcase
            end else if (wd_expired) begin
              // Master presumed hung: report without issuing STOP.
              state_d = k_SEQ_DONE;
              phase_d = k_PH_ISSUE;
              err_d   = 1'b1;
              tmo_d   = 1'b1;
`ifdef I2C_SEQ_RETRY_EN
              retry_d = 1'b0;
`endif
            end
          end
        endcase
      end
    endcase

    // Address-byte NACK: release the bus with STOP, then either retry or fail.
    if (dev_nack) begin
      state_d = k_SEQ_STOP;
`ifdef I2C_SEQ_RETRY_EN
      if (retry_cnt_q != 2'd3) begin
        retry_cnt_d = retry_cnt_q + 2'd1;
        retry_d     = 1'b1;
      end else begin
        err_d = 1'b1;
      end
`else
      err_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= k_SEQ_IDLE;
      phase_q <= k_PH_ISSUE;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef I2C_SEQ_RETRY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retry_cnt_q <= '0;
      retry_q     <= 1'b0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
      retry_q     <= retry_d;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb/tb_i2c_reg_sequencer.sv - directed self-checking bench for i2c_reg_sequencer
module tb_i2c_reg_sequencer;
  import i2c_reg_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_dev_addr = '0;
  logic [7:0] req_reg_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       resp_valid;
  logic [7:0] resp_rdata;
  logic       resp_err;
  logic       resp_timeout;
  logic [2:0] cmd;
  logic       write;
  logic [7:0] data_in;
  logic       nack;
  logic       ready_out = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_ack = 1'b1;

  int n_tests = 0;
  int n_fail = 0;

  // Master model state and command log.
  logic [2:0] log_cmd  [0:31];
  logic [7:0] log_data [0:31];
  logic       log_nack [0:31];
  int         log_n = 0;
  logic       pend = 1'b0;
  logic       hang = 1'b0;
  logic       hang_en = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] hang_byte = '0;
  logic [7:0] nack_byte = '0;
  logic [7:0] rd_byte = '0;
  int         nack_left = 0;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_timeout(resp_timeout),
    .cmd(cmd), .write(write), .data_in(data_in), .nack(nack),
    .ready_out(ready_out), .rx_data(rx_data), .rx_ack(rx_ack)
  );

  always #5 clk = ~clk;

  // Zero-latency master: takes a command, drops ready_out for one cycle, then idles.
  always @(negedge clk) begin
    if (reset) begin
      pend = 1'b0;
      hang = 1'b0;
      ready_out = 1'b1;
    end else begin
      if (hang || hold) ready_out = 1'b0;
      else if (pend) begin
        ready_out = 1'b0;
        pend = 1'b0;
      end else ready_out = 1'b1;
      if (write && ready_out) begin
        if (log_n < 32) begin
          log_cmd[log_n]  = cmd;
          log_data[log_n] = data_in;
          log_nack[log_n] = nack;
          log_n++;
        end
        pend = 1'b1;
        if (cmd == k_WRITE_CMD) begin
          if (nack_left > 0 && data_in == nack_byte) begin
            rx_ack = 1'b0;
            nack_left--;
          end else rx_ack = 1'b1;
          if (hang_en && data_in == hang_byte) hang = 1'b1;
        end
        if (cmd == k_READ_CMD) rx_data = rd_byte;
      end
    end
  end

  task automatic send_req(input logic rw, input logic [6:0] dev, input logic [7:0] ra,
                          input logic [7:0] wd, output logic ok);
    int guard;
    @(negedge clk); #1;
    req_valid = 1'b1; req_rw = rw; req_dev_addr = dev; req_reg_addr = ra; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    ok = req_ready;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output logic found, output logic [7:0] rd,
                           output logic er, output logic to);
    int cyc;
    found = 1'b0; rd = '0; er = 1'b0; to = 1'b0; cyc = 0;
    while (!found && cyc < budget) begin
      @(negedge clk); #1;
      cyc++;
      if (resp_valid) begin
        found = 1'b1; rd = resp_rdata; er = resp_err; to = resp_timeout;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    n_tests++;
    if ({req_ready, write, cmd, data_in, nack} !== {1'b0, 1'b0, k_START_CMD, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_cmd_side: ready/write/cmd/data/nack=%b/%b/%0d/%h/%b required 0/0/%0d/00/0",
               req_ready, write, cmd, data_in, nack, k_START_CMD);
    end
    n_tests++;
    if ({resp_valid, resp_rdata, resp_err, resp_timeout} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_resp_side: valid/rdata/err/tmo=%b/%h/%b/%b required all zero",
               resp_valid, resp_rdata, resp_err, resp_timeout);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_write;
    logic ok, found, er, to;
    logic [7:0] rd;
    logic [2:0] ec [0:4];
    logic [7:0] ed [0:4];
    ec[0] = k_START_CMD; ec[1] = k_WRITE_CMD; ec[2] = k_WRITE_CMD; ec[3] = k_WRITE_CMD; ec[4] = k_STOP_CMD;
    ed[0] = 8'h00; ed[1] = 8'hA0; ed[2] = 8'h10; ed[3] = 8'hA5; ed[4] = 8'h00;
    log_n = 0;
    send_req(1'b0, 7'h50, 8'h10, 8'hA5, ok);
    n_tests++;
    if (!(ok === 1'b1 && write === 1'b1 && cmd === k_START_CMD && req_ready === 1'b0)) begin
      n_fail++;
      $display("FAIL write_start_next_cycle: ok/write/cmd/req_ready=%b/%b/%0d/%b required 1/1/%0d/0",
               ok, write, cmd, req_ready, k_START_CMD);
    end
    wait_resp(200, found, rd, er, to);
    n_tests++;
    if ({found, er, to} !== 3'b100) begin
      n_fail++;
      $display("FAIL write_resp: found/err/tmo=%b/%b/%b required 1/0/0", found, er, to);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_resp_pulse: resp_valid/req_ready=%b/%b required 0/1", resp_valid, req_ready);
    end
    n_tests++;
    if (log_n !== 5) begin
      n_fail++;
      $display("FAIL write_cmd_count: %0d commands required 5", log_n);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (log_cmd[i] !== ec[i] || (ec[i] == k_WRITE_CMD && log_data[i] !== ed[i])) begin
        n_fail++;
        $display("FAIL write_cmd[%0d]: cmd/data=%0d/%h required %0d/%h", i, log_cmd[i], log_data[i], ec[i], ed[i]);
      end
    end
  endtask

  task automatic test_read;
    logic ok, found, er, to;
    logic [7:0] rd;
    logic [2:0] ec [0:6];
    logic [7:0] ed [0:6];
    ec[0] = k_START_CMD; ec[1] = k_WRITE_CMD; ec[2] = k_WRITE_CMD; ec[3] = k_RESTART_CMD;
    ec[4] = k_WRITE_CMD; ec[5] = k_READ_CMD;  ec[6] = k_STOP_CMD;
    ed[0] = 8'h00; ed[1] = 8'hA0; ed[2] = 8'h20; ed[3] = 8'h00; ed[4] = 8'hA1; ed[5] = 8'h00; ed[6] = 8'h00;
    log_n = 0;
    rd_byte = 8'h3C;
    send_req(1'b1, 7'h50, 8'h20, 8'hFF, ok);
    wait_resp(200, found, rd, er, to);
    n_tests++;
    if ({ok, found, rd, er, to} !== {1'b1, 1'b1, 8'h3C, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL read_resp: ok/found/rdata/err/tmo=%b/%b/%h/%b/%b required 1/1/3c/0/0", ok, found, rd, er, to);
    end
    n_tests++;
    if (log_n !== 7 || log_nack[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL read_cmd_count: %0d commands, read nack=%b required 7, 1", log_n, log_nack[5]);
    end
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (log_cmd[i] !== ec[i] || (ec[i] == k_WRITE_CMD && log_data[i] !== ed[i])) begin
        n_fail++;
        $display("FAIL read_cmd[%0d]: cmd/data=%0d/%h required %0d/%h", i, log_cmd[i], log_data[i], ec[i], ed[i]);
      end
    end
  endtask

  task automatic test_nack_reg;
    logic ok, found, er, to;
    logic [7:0] rd;
    log_n = 0;
    nack_byte = 8'h33;
    nack_left = 1;
    send_req(1'b0, 7'h50, 8'h33, 8'h77, ok);
    wait_resp(200, found, rd, er, to);
    n_tests++;
    // rdata must have been cleared by the accept (previous read left 3C).
    if ({ok, found, rd, er, to} !== {1'b1, 1'b1, 8'h00, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL nack_reg_resp: ok/found/rdata/err/tmo=%b/%b/%h/%b/%b required 1/1/00/1/0", ok, found, rd, er, to);
    end
    n_tests++;
    if (log_n !== 4 || log_cmd[2] !== k_WRITE_CMD || log_data[2] !== 8'h33 || log_cmd[3] !== k_STOP_CMD) begin
      n_fail++;
      $display("FAIL nack_reg_seq: n=%0d cmd2/data2=%0d/%h cmd3=%0d required 4 %0d/33 %0d",
               log_n, log_cmd[2], log_data[2], log_cmd[3], k_WRITE_CMD, k_STOP_CMD);
    end
    nack_left = 0;
  endtask

  task automatic test_timeout;
    logic ok;
    int cyc, t_a, t_r;
    log_n = 0;
    hang_en = 1'b1;
    hang_byte = 8'hA0;
    t_a = -1; t_r = -1; cyc = 0;
    send_req(1'b0, 7'h50, 8'h10, 8'hA5, ok);
    while (t_r < 0 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
      if (write && ready_out && cmd == k_WRITE_CMD && data_in == 8'hA0) t_a = cyc;
      if (resp_valid) t_r = cyc;
    end
    // DEV_W accepted, 1 ignored cycle, 16 counting cycles, abort cycle, then DONE.
    n_tests++;
    if (t_a < 0 || t_r - t_a !== 19) begin
      n_fail++;
      $display("FAIL timeout_latency: accept@%0d resp@%0d diff=%0d required 19", t_a, t_r, t_r - t_a);
    end
    n_tests++;
    if ({resp_err, resp_timeout} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_flags: err/tmo=%b/%b required 1/1", resp_err, resp_timeout);
    end
    repeat (4) @(negedge clk);
    #1;
    n_tests++;
    if (log_n !== 2 || resp_timeout !== 1'b1 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_no_stop: cmds=%0d tmo_hold=%b req_ready=%b required 2/1/1", log_n, resp_timeout, req_ready);
    end
    hang_en = 1'b0;
    hang = 1'b0;
  endtask

  task automatic test_issue_stall;
    logic ok, found, er, to, early;
    logic [7:0] rd;
    log_n = 0;
    hold = 1'b1;
    early = 1'b0;
    send_req(1'b0, 7'h22, 8'h05, 8'h5A, ok);
    repeat (30) begin
      @(negedge clk); #1;
      if (resp_valid) early = 1'b1;
    end
    n_tests++;
    if ({write, cmd, early} !== {1'b1, k_START_CMD, 1'b0}) begin
      n_fail++;
      $display("FAIL issue_stall_hold: write/cmd/early_resp=%b/%0d/%b required 1/%0d/0", write, cmd, early, k_START_CMD);
    end
    hold = 1'b0;
    wait_resp(200, found, rd, er, to);
    n_tests++;
    if ({found, er, to} !== 3'b100 || log_n !== 5 || log_data[1] !== 8'h44) begin
      n_fail++;
      $display("FAIL issue_stall_done: found/err/tmo=%b/%b/%b cmds=%0d dev=%h required 1/0/0 5 44",
               found, er, to, log_n, log_data[1]);
    end
  endtask

  task automatic test_reset_mid;
    logic ok, found, er, to, seen;
    logic [7:0] rd;
    log_n = 0;
    seen = 1'b0;
    send_req(1'b0, 7'h50, 8'h6B, 8'hC3, ok);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #1;
      if (write && cmd == k_WRITE_CMD && data_in == 8'h6B) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_reach_reg: reg write seen=%b required 1", seen);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({write, req_ready, cmd, data_in} !== {1'b0, 1'b0, k_START_CMD, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_async: write/req_ready/cmd/data=%b/%b/%0d/%h required 0/0/%0d/00",
               write, req_ready, cmd, data_in, k_START_CMD);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if ({write, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_mid_release: write/req_ready=%b/%b required 0/1", write, req_ready);
    end
    repeat (3) @(negedge clk);
    #1;
    log_n = 0;
    rd_byte = 8'h96;
    send_req(1'b1, 7'h50, 8'h20, 8'h00, ok);
    wait_resp(200, found, rd, er, to);
    n_tests++;
    if ({found, rd, er, to} !== {1'b1, 8'h96, 1'b0, 1'b0} || log_n !== 7) begin
      n_fail++;
      $display("FAIL reset_mid_recover: found/rdata/err/tmo=%b/%h/%b/%b cmds=%0d required 1/96/0/0 7",
               found, rd, er, to, log_n);
    end
  endtask

  task automatic test_dev_nack;
    logic ok, found, er, to;
    logic [7:0] rd;
    int starts;
    log_n = 0;
    nack_byte = 8'hA0;
`ifdef I2C_SEQ_RETRY_EN
    nack_left = 2;
    send_req(1'b0, 7'h50, 8'h10, 8'hA5, ok);
    wait_resp(400, found, rd, er, to);
    starts = 0;
    for (int i = 0; i < log_n; i++) if (log_cmd[i] == k_START_CMD) starts++;
    n_tests++;
    if ({found, er, to} !== 3'b100 || starts !== 3 || log_n !== 11) begin
      n_fail++;
      $display("FAIL retry_two_nacks: found/err/tmo=%b/%b/%b starts=%0d cmds=%0d required 1/0/0 3 11",
               found, er, to, starts, log_n);
    end
    log_n = 0;
    nack_left = 4;
    send_req(1'b0, 7'h50, 8'h10, 8'hA5, ok);
    wait_resp(400, found, rd, er, to);
    starts = 0;
    for (int i = 0; i < log_n; i++) if (log_cmd[i] == k_START_CMD) starts++;
    n_tests++;
    if ({found, er, to} !== 3'b110 || starts !== 4 || log_n !== 12) begin
      n_fail++;
      $display("FAIL retry_exhausted: found/err/tmo=%b/%b/%b starts=%0d cmds=%0d required 1/1/0 4 12",
               found, er, to, starts, log_n);
    end
`else
    nack_left = 1;
    send_req(1'b0, 7'h50, 8'h10, 8'hA5, ok);
    wait_resp(200, found, rd, er, to);
    starts = 0;
    for (int i = 0; i < log_n; i++) if (log_cmd[i] == k_START_CMD) starts++;
    n_tests++;
    if ({found, er, to} !== 3'b110 || starts !== 1 || log_n !== 3 || log_cmd[2] !== k_STOP_CMD) begin
      n_fail++;
      $display("FAIL dev_nack_fail: found/err/tmo=%b/%b/%b starts=%0d cmds=%0d last=%0d required 1/1/0 1 3 %0d",
               found, er, to, starts, log_n, log_cmd[2], k_STOP_CMD);
    end
`endif
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL dev_nack_accept: ok=%b required 1", ok);
    end
    nack_left = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack_reg();
    test_timeout();
    test_issue_stall();
    test_reset_mid();
    test_dev_nack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Transaction sequencer that sits directly upstream of the bit-level I2C master. It turns one host register-access request, write or read of an 8-bit register on a 7-bit device address, into the ordered START/WRITE/RESTART/READ/STOP command stream that the master consumes. It returns read data and ACK/NACK status to the host, and guards each master command with a watchdog.

## Interface
- TIMEOUT_CYCLES, 16'hFFFF: max cycles to wait for master completion of one command before abort.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  host request strobe.
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
- req_rw  in  1  0 = register write, 1 = register read.
- req_dev_addr  in  7  target device address.
- req_reg_addr  in  8  register index.
- req_wdata  in  8  write data; ignored for reads.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  8  read byte; valid with resp_valid when req_rw=1.
- resp_err  out  1  transaction failed, either slave NACK or timeout.
- resp_timeout  out  1  failure was a watchdog timeout.
- cmd  out  3  command to master (k_*_CMD).
- write  out  1  command strobe to master.
- data_in  out  8  byte for WRITE commands.
- nack  out  1  for READ: 1 = master sends NACK after the byte.
- ready_out  in  1  master ready/idle.
- rx_data  in  8  byte from master's last READ.
- rx_ack  in  1  slave ACK sampled by master's last WRITE (1 = ACK).

## Operation
- Write sequence:
  - START
  - WRITE {dev,1'b0}
  - WRITE reg
  - WRITE wdata
  - STOP
- Read sequence:
  - START
  - WRITE {dev,1'b0}
  - WRITE reg
  - RESTART
  - WRITE {dev,1'b1}
  - READ with nack=1
  - STOP
- States: IDLE, START, DEV_W, REG, WDATA, RESTART, DEV_R, RDATA, STOP, DONE.
  - Each non-IDLE/DONE state has two phases: ISSUE and WAIT.
- Request fields are latched on accept and are stable for the whole transaction.
- ISSUE phase:
  - write=1 with cmd/data_in/nack driven.
  - Held until write && ready_out, then move to WAIT.
- WAIT phase:
  - The cycle after acceptance is ignored, because the master drops ready_out.
  - Thereafter, wait for ready_out=1; rx_data and rx_ack are sampled on that cycle.
- NACK handling: rx_ack=0 after any WRITE sets the error flag and jumps to STOP ISSUE. The remaining sequence is skipped.
- RDATA completion captures rx_data into resp_rdata.
- STOP completion goes to DONE: resp_valid=1 for one cycle, then IDLE.
- Watchdog: a 16-bit counter clears on every ISSUE→WAIT transition and increments in WAIT. When it equals TIMEOUT_CYCLES:
  - go to DONE directly; no STOP is issued, since the master is presumed hung.
  - resp_err=1, resp_timeout=1.
- resp_rdata, resp_err and resp_timeout hold until the next accept, when they clear.

## Timing
- Reset values:
  - req_ready=0 during reset, then 1 (IDLE).
  - resp_valid=0, resp_rdata=0, resp_err=0, resp_timeout=0.
  - write=0, cmd=k_START_CMD, data_in=0, nack=0.
- Accept at cycle N: START ISSUE (write=1) at N+1.
- With a zero-latency master, the minimum is 3 cycles per command. DONE adds 1 cycle.
- req_ready=0 from the accept cycle+1 until DONE. It is 1 again the cycle after resp_valid.
- Reset mid-transaction: immediate return to IDLE, all outputs to reset values, no STOP generated.
- ready_out low while in ISSUE: write stays high and no timeout applies in ISSUE.
- Timeout while TIMEOUT_CYCLES=0: abort on the first WAIT cycle after the ignored cycle.

## Configuration
- I2C_SEQ_RETRY_EN defined: NACK on DEV_W or DEV_R retries the whole transaction.
  - A retry is STOP, then restart from START.
  - Up to 3 retries (2-bit retry counter). resp_err is reported only after the 4th NACK.
  - NACK on REG or WDATA still fails immediately.
- I2C_SEQ_RETRY_EN undefined: every NACK fails immediately. The retry counter is not synthesized.

## Structure
- Shared package include/i2c.vh holds:
  - the k_*_CMD codes (k_START_CMD, k_WRITE_CMD, k_READ_CMD, k_STOP_CMD, k_RESTART_CMD);
  - the new sequencer state localparams (k_SEQ_*).
- Sub-module i2c_cmd_watchdog: the 16-bit counter with clear/enable/expired.

## Test plan
- Write dev=7'h50, reg=8'h10, wdata=8'hA5, master model always ACKs:
  - commands START, WRITE 8'hA0, WRITE 8'h10, WRITE 8'hA5, STOP;
  - resp_valid once, resp_err=0.
- Read dev=7'h50, reg=8'h20, model returns 8'h3C:
  - commands START, WRITE 8'hA0, WRITE 8'h20, RESTART, WRITE 8'hA1, READ with nack=1, STOP;
  - resp_rdata=8'h3C.
- Model NACKs the REG byte: next command is STOP, then resp_err=1, resp_timeout=0.
- Model holds ready_out low after the DEV_W accept, TIMEOUT_CYCLES=16:
  - resp_valid with resp_err=1, resp_timeout=1 after 17 WAIT cycles;
  - no STOP issued.
- Reset asserted during WRITE reg:
  - write=0, req_ready=1 after release;
  - a new request then completes normally.
- With I2C_SEQ_RETRY_EN, model NACKs DEV_W twice then ACKs: three START commands seen, final resp_err=0.
